// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: feeds a parallel word MSB-first into a serial Mealy detector,
// counts its match pulses and returns a {count, first, any} result record.
module seq_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_data,
    output logic             word_ready,
    input  logic             abort,
    output logic             det_clr,
    output logic             det_en,
    output logic             det_in,
    input  logic             det_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic [CNT_W-1:0] res_first,
    output logic             res_any
);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_idx;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] first_pos;
    logic             any_seen;

    logic [CNT_W-1:0] cnt_upd;
    logic [CNT_W-1:0] first_upd;
    logic             any_upd;
    logic             last_bit;
    logic             accept;
    logic             shifting;

    // Match accumulation for the current bit; the detector output only counts in SHIFT.
    always_comb begin
        cnt_upd   = match_cnt;
        first_upd = first_pos;
        any_upd   = any_seen;
        last_bit  = (bit_idx == CNT_W'(WIDTH - 1));
        if (state == SHIFT && det_y) begin
            if (match_cnt != '1) begin
                cnt_upd = match_cnt + 1'b1;
            end
            if (!any_seen) begin
                first_upd = bit_idx;
                any_upd   = 1'b1;
            end
        end
    end

    // Next-state and handshake/detector control; abort overrides normal flow.
    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        det_clr    = 1'b0;
        det_en     = 1'b0;
        det_in     = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        shifting   = 1'b0;
        case (state)
            IDLE: begin
                word_ready = !abort;
                if (word_valid && !abort) begin
                    accept     = 1'b1;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                det_clr    = 1'b1;
                state_next = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    det_clr    = 1'b1;
                    state_next = IDLE;
                end else begin
                    det_en   = 1'b1;
                    det_in   = shreg[WIDTH-1];
                    shifting = 1'b1;
                    if (last_bit) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (abort || res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and result registers; results latch only on the last shifted bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            match_cnt <= '0;
            first_pos <= '0;
            any_seen  <= 1'b0;
            res_count <= '0;
            res_first <= '0;
            res_any   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                shreg     <= word_data;
                bit_idx   <= '0;
                match_cnt <= '0;
                first_pos <= '0;
                any_seen  <= 1'b0;
            end else if (shifting) begin
                shreg     <= {shreg[WIDTH-2:0], 1'b0};
                bit_idx   <= bit_idx + 1'b1;
                match_cnt <= cnt_upd;
                first_pos <= first_upd;
                any_seen  <= any_upd;
                if (last_bit) begin
                    res_count <= cnt_upd;
                    res_first <= first_upd;
                    res_any   <= any_upd;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: drives words into seq_scan_ctrl with a non-overlapping "11011"
// detector model attached, and checks results through an expected-result queue.
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_ready;
    logic        abort;
    logic        det_clr;
    logic        det_en;
    logic        det_in;
    logic        det_y;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_count;
    logic [4:0]  res_first;
    logic        res_any;

    typedef struct {
        logic [15:0] word;
        logic [4:0]  cnt;
        logic [4:0]  first;
        logic        any;
    } vec_t;

    vec_t vecs[6];
    vec_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    logic [2:0] dstate;

    seq_scan_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .abort      (abort),
        .det_clr    (det_clr),
        .det_en     (det_en),
        .det_in     (det_in),
        .det_y      (det_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_count  (res_count),
        .res_first  (res_first),
        .res_any    (res_any)
    );

    always #5 clk = ~clk;

    // Mealy match output: fires on the final '1' of 11011 while enabled.
    always_comb det_y = det_en && det_in && (dstate == 3'd4);

    // Detector prefix-length state; restarts after a match (non-overlapping).
    always @(posedge clk) begin
        if (reset || det_clr) begin
            dstate <= 3'd0;
        end else if (det_en) begin
            case (dstate)
                3'd0:    dstate <= det_in ? 3'd1 : 3'd0;
                3'd1:    dstate <= det_in ? 3'd2 : 3'd0;
                3'd2:    dstate <= det_in ? 3'd2 : 3'd3;
                3'd3:    dstate <= det_in ? 3'd4 : 3'd0;
                default: dstate <= 3'd0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_word_ready"}, 32'(word_ready), 32'd1);
        check({tag, "_res_valid"},  32'(res_valid),  32'd0);
        check({tag, "_det_clr"},    32'(det_clr),    32'd0);
        check({tag, "_det_en"},     32'(det_en),     32'd0);
        check({tag, "_det_in"},     32'(det_in),     32'd0);
        check({tag, "_res_count"},  32'(res_count),  32'd0);
        check({tag, "_res_first"},  32'(res_first),  32'd0);
        check({tag, "_res_any"},    32'(res_any),    32'd0);
    endtask

    // Present a word and wait for its accepting edge; cyc is 1 in the CLEAR cycle.
    task automatic applyStimulus(input vec_t v, input bit push);
        int guard = 0;
        while (!word_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!word_ready) begin
            mismatched++;
            $display("[TB] FAIL accept_timeout: got word_ready=0, expected 1");
        end
        word_valid = 1'b1;
        word_data  = v.word;
        @(posedge clk); #1;
        word_valid = 1'b0;
        if (push) sb.push_back(v);
        cyc = 1;
    endtask

    // Follow a scan to DONE, check it against the queue head, optionally stall, then acknowledge.
    task automatic checkOutput(input int stall);
        vec_t        exp;
        int          clrs = 0;
        int          ens  = 0;
        logic [15:0] cap  = '0;
        while (!res_valid && cyc < 40) begin
            clrs += int'(det_clr);
            if (det_en) begin
                ens++;
                cap = {cap[14:0], det_in};
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'd18);
        check("det_clr_pulses", 32'(clrs), 32'd1);
        check("det_en_cycles", 32'(ens), 32'd16);
        if (sb.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        exp = sb.pop_front();
        check("det_in_stream", 32'(cap), 32'(exp.word));
        check("res_count", 32'(res_count), 32'(exp.cnt));
        check("res_first", 32'(res_first), 32'(exp.first));
        check("res_any",   32'(res_any),   32'(exp.any));
        for (int i = 0; i < stall; i++) begin
            word_valid = 1'b1;
            word_data  = 16'hFFFF;
            @(posedge clk); #1;
            check("stall_res_valid",  32'(res_valid),  32'd1);
            check("stall_word_ready", 32'(word_ready), 32'd0);
            check("stall_res_count",  32'({res_count, res_first, res_any}),
                  32'({exp.cnt, exp.first, exp.any}));
        end
        word_valid = 1'b0;
        res_ready  = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("ack_res_valid",  32'(res_valid),  32'd0);
        check("ack_word_ready", 32'(word_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hits;
        vecs[0] = '{16'hD800, 5'd1, 5'd4,  1'b1};
        vecs[1] = '{16'hDB60, 5'd2, 5'd4,  1'b1};
        vecs[2] = '{16'h0000, 5'd0, 5'd0,  1'b0};
        vecs[3] = '{16'hFFFF, 5'd0, 5'd0,  1'b0};
        vecs[4] = '{16'h6C00, 5'd1, 5'd5,  1'b1};
        vecs[5] = '{16'h001B, 5'd1, 5'd15, 1'b1};

        reset = 1'b1; word_valid = 1'b0; word_data = '0; abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] table-driven scans");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], 1'b1);
            checkOutput(0);
        end

        $display("[TB] result stall with word_valid held");
        applyStimulus(vecs[0], 1'b1);
        checkOutput(10);
        applyStimulus(vecs[1], 1'b1);
        checkOutput(0);

        $display("[TB] abort in IDLE");
        abort = 1'b1; word_valid = 1'b1; word_data = 16'hD800;
        #1;
        check("idle_abort_word_ready", 32'(word_ready), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0; word_valid = 1'b0;
        #1;
        check("idle_abort_no_clear", 32'({det_clr, det_en, word_ready}), 32'b001);

        $display("[TB] abort at bit index 7");
        applyStimulus(vecs[1], 1'b0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        #1;
        check("abort_det_clr", 32'(det_clr), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        #1;
        check("abort_idle", 32'({word_ready, res_valid, det_en, det_clr}), 32'b1000);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            hits += int'(res_valid);
        end
        check("abort_no_result", 32'(hits), 32'd0);
        applyStimulus(vecs[0], 1'b1);
        checkOutput(0);

        $display("[TB] reset with abort during SHIFT");
        applyStimulus(vecs[1], 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; abort = 1'b0;
        #1;
        checkResetOutputs("rst_abort");

        $display("[TB] reset during SHIFT after a completed scan");
        applyStimulus(vecs[4], 1'b1);
        checkOutput(0);
        applyStimulus(vecs[1], 1'b0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkResetOutputs("rst_shift");
        applyStimulus(vecs[5], 1'b1);
        checkOutput(0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Controller that sequences a serial sequence detector over parallel data words. It accepts a WIDTH-bit word through a valid/ready handshake and clears the detector. It then streams the word MSB-first into the detector's serial input, one bit per clock, and counts the detector's match pulses. It returns a result record (match count, first match position, any-match flag) through a second valid/ready handshake. It sits between a word-producing front end and any single-bit Mealy detector in the design that has a synchronous clear and enable.

## Interface
Parameters:
- WIDTH, 16, bits per scanned word (≥ 2)
- CNT_W, 5, width of count and position fields; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- word_valid  in  1  input word available
- word_data  in  WIDTH  word to scan, bit WIDTH-1 first
- word_ready  out  1  block can accept a word
- abort  in  1  cancel current scan; synchronous
- det_clr  out  1  one-cycle clear to detector (detector returns to its initial state)
- det_en  out  1  detector advances this cycle
- det_in  out  1  serial bit presented to detector
- det_y  in  1  detector match output, Mealy (combinational on det_in)
- res_valid  out  1  result record valid
- res_ready  in  1  consumer accepts result
- res_count  out  CNT_W  number of det_y pulses in the scan, saturating
- res_first  out  CNT_W  bit index (0 = MSB) of first match; 0 if none
- res_any  out  1  at least one match occurred

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE: word_ready=1. On word_valid, load word_data into shift register, zero bit index, count, first, any; go to CLEAR.
- CLEAR: det_clr=1 for exactly one cycle, det_en=0; go to SHIFT.
- SHIFT: det_en=1, det_in=shreg[WIDTH-1]. Sample det_y in the same cycle. On det_y=1:
  - count increments, holding at 2^CNT_W-1.
  - If any=0: first <= current bit index, any <= 1.
- SHIFT, every cycle: shift register shifts left by 1 and the bit index increments. After the bit with index WIDTH-1, go to DONE.
- DONE: res_valid=1 and result fields stable. On res_ready=1, go to IDLE, where res_valid=0.
- det_y is ignored in IDLE, CLEAR and DONE.
- abort=1 in CLEAR or SHIFT: go to IDLE next cycle, assert det_clr that cycle, no result produced.
- abort=1 in DONE: drop the result and go to IDLE.
- abort=1 in IDLE: no effect on state. word_ready is forced 0 that cycle, so no word is accepted.
- Priority: reset > abort > normal transitions.

## Timing
- Reset values:
  - word_ready=1, res_valid=0, det_clr=0, det_en=0, det_in=0.
  - res_count=0, res_first=0, res_any=0, state=IDLE.
- det_in=0 and det_en=0 outside SHIFT. det_clr is high only in CLEAR or on an abort cycle.
- Latency: word accepted on edge T.
  - CLEAR spans cycle T+1.
  - SHIFT spans cycles T+2 .. T+WIDTH+1.
  - res_valid rises at T+WIDTH+2 (18 cycles for WIDTH=16).
- Throughput: the earliest next accept is the cycle after the res_valid&&res_ready cycle, so one word per WIDTH+3 cycles minimum.
- Result fields update only on the final SHIFT cycle and hold through DONE regardless of res_ready stalls.
- A match on the last bit (index WIDTH-1) is counted.
- Reset asserted mid-SHIFT: the next cycle is IDLE with all outputs at reset values. No det_clr is issued, because the detector shares the same reset.

## Test plan
- Word 16'hD800 through a non-overlapping "11011" detector model -> res_count=1, res_first=4, res_any=1; res_valid rises 18 cycles after accept.
- Word 16'hDB60 -> det_y pulses at indices 4 and 10; res_count=2, res_first=4, res_any=1.
- Word 16'h0000 -> res_count=0, res_first=0, res_any=0; det_clr seen exactly once, det_en high for exactly 16 cycles.
- Hold res_ready=0 for 10 cycles in DONE with word_valid=1 -> res_valid and fields stable, word_ready=0. Release -> IDLE, next word accepted the following cycle.
- Assert abort at SHIFT bit index 7 of 16'hDB60 -> det_clr pulse and IDLE next cycle, no res_valid. Then scan 16'hD800 -> count=1, first=4 (no carried state).
- Assert reset during SHIFT -> all outputs at reset values next cycle. Also check simultaneous reset+abort gives reset behaviour.
